uart_frame_parser: RTL

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_parser.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Extracts framed payloads from a UART byte stream and hands them to a
//   valid/ready consumer. Frame: 0x55, 0xAA, LEN, LEN payload bytes[, CHK].
//   CHK is the modulo-256 sum of LEN and the payload bytes.
//
//   Build option: define FRAME_CHECKSUM_EN to expect and verify the CHK byte.
//   Without it there is no CHK byte, the frame is released straight after the
//   last payload byte and BAD_CHK never occurs.
//
// Ports
//   sys_clk    in   clock, rising edge
//   sys_rst    in   asynchronous active-high reset
//   in_data    in   [7:0] received byte, valid while in_flag=1
//   in_flag    in   one-cycle strobe per received byte
//   frm_data   out  [7:0] payload byte (0x00 when frm_valid=0)
//   frm_valid  out  frm_data is valid
//   frm_ready  in   consumer accepts frm_data
//   frm_last   out  final payload byte of the frame
//   err_flag   out  one-cycle pulse per frame error
//   err_code   out  [1:0] 0=BAD_LEN 1=BAD_CHK 2=TIMEOUT 3=OVERRUN, held
//
// State | meaning
// HDR0  | hunting for 0x55
// HDR1  | got 0x55, expecting 0xAA
// LEN   | expecting length byte
// PAY   | collecting payload into the buffer
// CHK   | expecting checksum byte (FRAME_CHECKSUM_EN only)
// OUT   | presenting buffered payload to the consumer
module uart_frame_parser #(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] in_data,
  input  logic       in_flag,
  output logic [7:0] frm_data,
  output logic       frm_valid,
  input  logic       frm_ready,
  output logic       frm_last,
  output logic       err_flag,
  output logic [1:0] err_code
);

  localparam int PW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BUF_D = 1 << PW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] E_BAD_LEN = 2'd0;
  localparam logic [1:0] E_BAD_CHK = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_LEN, S_PAY, S_CHK, S_OUT
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    len_q, wr_ptr, rd_ptr;
  logic [7:0]    buf_mem [0:BUF_D-1];
  logic [TW-1:0] tmo_cnt;
  logic          err_set;
  logic [1:0]    err_type;
  logic          last_pay, last_out, xfer, timed_state, tmo_hit;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    sum_q;
`endif

  assign last_pay    = (wr_ptr == len_q - 8'd1);
  assign last_out    = (rd_ptr == len_q - 8'd1);
  assign xfer        = frm_valid && frm_ready;
  assign timed_state = (state == S_HDR1) || (state == S_LEN) ||
                       (state == S_PAY)  || (state == S_CHK);
  // The counter reloads on every strobe, so reaching 1 with no strobe this
  // cycle means TIMEOUT_CYC idle cycles have elapsed.
  assign tmo_hit     = timed_state && !in_flag && (tmo_cnt == TMO_ONE);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_HDR0;
    else         state <= state_nxt;
  end

  // Next-state and error decode
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_type  = E_BAD_LEN;
    if (tmo_hit) begin
      state_nxt = S_HDR0;
      err_set   = 1'b1;
      err_type  = E_TIMEOUT;
    end else begin
      case (state)
        S_HDR0: if (in_flag && in_data == 8'h55) state_nxt = S_HDR1;
        S_HDR1: if (in_flag) begin
          if (in_data == 8'hAA)      state_nxt = S_LEN;
          else if (in_data != 8'h55) state_nxt = S_HDR0;
        end
        S_LEN: if (in_flag) begin
          if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
            state_nxt = S_HDR0;
            err_set   = 1'b1;
            err_type  = E_BAD_LEN;
          end else begin
            state_nxt = S_PAY;
          end
        end
        S_PAY: if (in_flag && last_pay) begin
`ifdef FRAME_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_OUT;
`endif
        end
`ifdef FRAME_CHECKSUM_EN
        S_CHK: if (in_flag) begin
          if (in_data == sum_q) begin
            state_nxt = S_OUT;
          end else begin
            state_nxt = S_HDR0;
            err_set   = 1'b1;
            err_type  = E_BAD_CHK;
          end
        end
`endif
        S_OUT: begin
          if (in_flag) begin
            err_set  = 1'b1;
            err_type = E_OVERRUN;
          end
          if (xfer && last_out) state_nxt = S_HDR0;
        end
        default: state_nxt = S_HDR0;
      endcase
    end
  end

  // Outputs; the buffer read is only meaningful in OUT
  always_comb begin
    frm_valid = (state == S_OUT);
    frm_last  = frm_valid && last_out;
    frm_data  = frm_valid ? buf_mem[rd_ptr[PW-1:0]] : 8'h00;
  end

  // Datapath: pointers, length, sum, timeout, error registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      len_q    <= 8'd0;
      wr_ptr   <= 8'd0;
      rd_ptr   <= 8'd0;
      tmo_cnt  <= '0;
      err_flag <= 1'b0;
      err_code <= E_BAD_LEN;
`ifdef FRAME_CHECKSUM_EN
      sum_q    <= 8'd0;
`endif
    end else begin
      err_flag <= err_set;
      if (err_set) err_code <= err_type;

      if (in_flag)            tmo_cnt <= TMO_LOAD;
      else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TMO_ONE;

      if (state_nxt == S_HDR0) begin
        wr_ptr <= 8'd0;
        rd_ptr <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
        sum_q  <= 8'd0;
`endif
      end else begin
        if (state == S_LEN && in_flag) len_q  <= in_data;
        if (state == S_PAY && in_flag) wr_ptr <= wr_ptr + 8'd1;
        if (xfer)                      rd_ptr <= rd_ptr + 8'd1;
`ifdef FRAME_CHECKSUM_EN
        // LEN is folded in too; sum_q is zero when LEN arrives.
        if ((state == S_LEN || state == S_PAY) && in_flag)
          sum_q <= sum_q + in_data;
`endif
      end
    end
  end

  // Payload buffer, no reset needed
  always_ff @(posedge sys_clk) begin
    if (state == S_PAY && in_flag) buf_mem[wr_ptr[PW-1:0]] <= in_data;
  end

endmodule
